// File: rtl/axis_uart_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : axis_uart_frame_rx
//  Purpose  : Store-and-forward SOF/LEN/payload/XOR-CHK frame parser that
//             releases good payloads on an AXI-Stream master with tlast.
//  Revision : 1.0  initial release
// ============================================================================
module axis_uart_frame_rx #(
    parameter int         CLOCK         = 100_000_000,
    parameter int         BAUD_RATE     = 115_200,
    parameter int         TIMEOUT_BYTES = 4,
    parameter logic [7:0] SOF           = 8'hA5,
    parameter int         MAX_LEN       = 64
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    // 64-bit product: the default parameters overflow 32-bit arithmetic.
    localparam longint     TIMEOUT_CYCLES_L = (longint'(TIMEOUT_BYTES) * 64'sd10 * longint'(CLOCK))
                                              / longint'(BAUD_RATE);
    localparam int         TIMEOUT_CYCLES   = int'(TIMEOUT_CYCLES_L);
    localparam int         GAP_W            = $clog2(TIMEOUT_CYCLES + 1);
    localparam int         IDX_W            = $clog2(MAX_LEN + 1);
    localparam int         ADDR_W           = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_LEN_B        = 8'(MAX_LEN);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHK     = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         xor_q, xor_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               ok_q, ok_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic               tready_q, tready_d;
    logic [7:0]         buf_q [MAX_LEN];

    logic               w_accept;
    logic               w_m_hs;
    logic               w_we;
    logic               w_in_frame;
    logic [IDX_W-1:0]   w_ridx_nxt;

    assign w_accept   = s_axis_tvalid & tready_q;
    assign w_m_hs     = tvalid_q & m_axis_tready;
    assign w_in_frame = (state_q == ST_LEN) || (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    assign w_ridx_nxt = ridx_q + IDX_W'(1);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        xor_d    = xor_q;
        widx_d   = widx_q;
        ridx_d   = ridx_q;
        gap_d    = gap_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
        w_we     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gap_d = '0;
                if (w_accept && (s_axis_tdata == SOF)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_accept) begin
                    gap_d = '0;
                    if ((s_axis_tdata == 8'd0) || (s_axis_tdata > MAX_LEN_B)) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        len_d   = s_axis_tdata;
                        xor_d   = s_axis_tdata;
                        widx_d  = '0;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (w_accept) begin
                    gap_d  = '0;
                    w_we   = 1'b1;
                    xor_d  = xor_q ^ s_axis_tdata;
                    widx_d = widx_q + IDX_W'(1);
                    if ((8'(widx_q) + 8'd1) == len_q) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (w_accept) begin
                    gap_d = '0;
                    if (s_axis_tdata == xor_q) begin
                        state_d  = ST_DRAIN;
                        ok_d     = 1'b1;
                        ridx_d   = '0;
                        tvalid_d = 1'b1;
                        tdata_d  = buf_q[0];
                        tlast_d  = (len_q == 8'd1);
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                    end
                end
            end
            ST_DRAIN: begin
                gap_d = '0;
                if (w_m_hs) begin
                    if (tlast_q) begin
                        state_d  = ST_IDLE;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                    end else begin
                        ridx_d  = w_ridx_nxt;
                        tdata_d = buf_q[w_ridx_nxt[ADDR_W-1:0]];
                        tlast_d = ((8'(ridx_q) + 8'd2) == len_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An accepted byte always beats the timeout in the same cycle.
        if (w_in_frame && !w_accept) begin
            if (gap_q == GAP_LAST) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
                code_d  = 2'd3;
                gap_d   = '0;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end

        tready_d = (state_d != ST_DRAIN);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            xor_q    <= '0;
            widx_q   <= '0;
            ridx_q   <= '0;
            gap_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            xor_q    <= xor_d;
            widx_q   <= widx_d;
            ridx_q   <= ridx_d;
            gap_q    <= gap_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            code_q   <= code_d;
            tready_q <= tready_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (!areset && w_we) begin
            buf_q[widx_q[ADDR_W-1:0]] <= s_axis_tdata;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;
    assign err_code      = code_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_uart_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_uart_frame_rx
//  Purpose  : Directed self-checking bench for axis_uart_frame_rx.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axis_uart_frame_rx;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready = 1'b1;
    logic       m_tlast;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    int n_vec  = 0;
    int n_miss = 0;
    int n_ok   = 0;
    int n_err  = 0;

    logic [7:0] tx_q[$];
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    logic       prev_stall = 1'b0;
    logic [8:0] prev_dat   = '0;

    // 200-cycle timeout: 2 byte times * 10 bits * 1000 Hz / 100 baud.
    axis_uart_frame_rx #(
        .CLOCK         (1000),
        .BAUD_RATE     (100),
        .TIMEOUT_BYTES (2),
        .SOF           (8'hA5),
        .MAX_LEN       (64)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        s_tdata  = b;
        s_tvalid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge aclk);
            done = s_tready;
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        if (!done) check("send_stuck", 32'd0, 32'd1);
    endtask

    task automatic send_q();
        foreach (tx_q[i]) send(tx_q[i]);
        tx_q.delete();
    endtask

    task automatic drain_wait();
        int k;
        k = 0;
        while (m_tvalid && k < 300) begin
            tick();
            k++;
        end
        if (k == 300) check("drain_stuck", 32'd0, 32'd1);
        tick();
    endtask

    task automatic cmp_frame(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    // Output monitor: collects handshakes and pulses, verifies hold under stall.
    always @(negedge aclk) begin
        if (areset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, m_tvalid}, 32'd1);
                check("hold_data", {23'd0, m_tlast, m_tdata}, {23'd0, prev_dat});
            end
            if (m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
            if (frame_ok)  n_ok++;
            if (frame_err) n_err++;
            prev_stall = m_tvalid && !m_tready;
            prev_dat   = {m_tlast, m_tdata};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok0;
        int err0;
        logic [7:0] x;
        logic [7:0] d;

        // Reset state
        repeat (3) tick();
        check("rst_tready", {31'd0, s_tready}, 32'd0);
        check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("rst_tlast",  {31'd0, m_tlast},  32'd0);
        check("rst_ok",     {31'd0, frame_ok}, 32'd0);
        check("rst_err",    {31'd0, frame_err}, 32'd0);
        check("rst_code",   {30'd0, err_code}, 32'd0);
        areset = 1'b0;
        tick();
        check("tready_rise", {31'd0, s_tready}, 32'd1);

        // 1: good frame, exact output timing
        tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
        send_q();
        check("s1_tready_rx", {31'd0, s_tready}, 32'd1);
        send(8'h03);
        check("s1_ok",     {31'd0, frame_ok}, 32'd1);
        check("s1_tvalid", {31'd0, m_tvalid}, 32'd1);
        check("s1_b0",     {24'd0, m_tdata},  32'h11);
        check("s1_tready", {31'd0, s_tready}, 32'd0);
        tick();
        tick();
        check("s1_tlast",  {31'd0, m_tlast},  32'd1);
        check("s1_tready_drain", {31'd0, s_tready}, 32'd0);
        tick();
        check("s1_done_valid", {31'd0, m_tvalid}, 32'd0);
        check("s1_done_ready", {31'd0, s_tready}, 32'd1);
        exp_q = {9'h011, 9'h022, 9'h133};
        cmp_frame("s1");
        check("s1_okcnt", n_ok, 32'd1);

        // 2: garbage then bad checksum, then LEN=1 frame
        tx_q = {8'h00, 8'hFF, 8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
        send_q();
        check("s2_err",    {31'd0, frame_err}, 32'd1);
        check("s2_code",   {30'd0, err_code},  32'd2);
        check("s2_tvalid", {31'd0, m_tvalid},  32'd0);
        tick();
        check("s2_err_pulse", {31'd0, frame_err}, 32'd0);
        tx_q = {8'hA5, 8'h01, 8'h5C, 8'h5D};
        send_q();
        check("s2_len1_tlast", {31'd0, m_tlast}, 32'd1);
        drain_wait();
        exp_q = {9'h15C};
        cmp_frame("s2");
        check("s2_errcnt", n_err, 32'd1);

        // 3: bad lengths and a MAX_LEN frame
        tx_q = {8'hA5, 8'h00};
        send_q();
        check("s3_len0_err",  {31'd0, frame_err}, 32'd1);
        check("s3_len0_code", {30'd0, err_code},  32'd1);
        tx_q = {8'hA5, 8'h01, 8'h77, 8'h00};
        send_q();
        check("s3_chk_code",  {30'd0, err_code},  32'd2);
        tx_q = {8'hA5, 8'h41};
        send_q();
        check("s3_len65_err",  {31'd0, frame_err}, 32'd1);
        check("s3_len65_code", {30'd0, err_code},  32'd1);
        tx_q = {8'hA5, 8'hA5};
        send_q();
        check("s3_lensof_err", {31'd0, frame_err}, 32'd1);
        x = 8'h40;
        tx_q = {8'hA5, 8'h40};
        for (int i = 0; i < 64; i++) begin
            d = 8'(i * 5 + 7);
            x = x ^ d;
            tx_q.push_back(d);
            exp_q.push_back({(i == 63), d});
        end
        tx_q.push_back(x);
        send_q();
        check("s3_max_ok", {31'd0, frame_ok}, 32'd1);
        drain_wait();
        cmp_frame("s3");

        // 4: timeout after 200 idle cycles; 199-cycle gap survives
        err0 = n_err;
        tx_q = {8'hA5, 8'h02, 8'h11};
        send_q();
        repeat (199) @(posedge aclk);
        #1;
        check("s4_no_early_to", {31'd0, frame_err}, 32'd0);
        tick();
        check("s4_to_err",  {31'd0, frame_err}, 32'd1);
        check("s4_to_code", {30'd0, err_code},  32'd3);
        check("s4_to_errcnt", n_err - err0, 32'd0);
        tick();
        check("s4_to_cnt", n_err - err0, 32'd1);
        tx_q = {8'hA5, 8'h02, 8'h11};
        send_q();
        repeat (199) @(posedge aclk);
        #1;
        tx_q = {8'h22, 8'h31};
        send_q();
        check("s4_gap_ok", {31'd0, frame_ok}, 32'd1);
        drain_wait();
        exp_q = {9'h011, 9'h122};
        cmp_frame("s4");

        // 5: output backpressure 1,0,0,1,0,1
        m_tready = 1'b0;
        tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_q();
        m_tready = 1'b1; tick();
        m_tready = 1'b0; tick();
        m_tready = 1'b0; tick();
        m_tready = 1'b1; tick();
        m_tready = 1'b0; tick();
        m_tready = 1'b1; tick();
        check("s5_done_valid", {31'd0, m_tvalid}, 32'd0);
        exp_q = {9'h011, 9'h022, 9'h133};
        cmp_frame("s5");

        // 6a: reset during PAYLOAD
        err0 = n_err;
        tx_q = {8'hA5, 8'h03, 8'h11};
        send_q();
        areset = 1'b1;
        tick();
        check("s6a_tready", {31'd0, s_tready}, 32'd0);
        check("s6a_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("s6a_err",    {31'd0, frame_err}, 32'd0);
        areset = 1'b0;
        tick();
        check("s6a_tready_back", {31'd0, s_tready}, 32'd1);
        tx_q = {8'hA5, 8'h01, 8'h5C, 8'h5D};
        send_q();
        drain_wait();
        exp_q = {9'h15C};
        cmp_frame("s6a");

        // 6b: reset during DRAIN while stalled
        m_tready = 1'b0;
        tx_q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        send_q();
        tick();
        areset = 1'b1;
        tick();
        check("s6b_tvalid", {31'd0, m_tvalid}, 32'd0);
        check("s6b_tlast",  {31'd0, m_tlast},  32'd0);
        check("s6b_ok",     {31'd0, frame_ok}, 32'd0);
        check("s6b_err",    {31'd0, frame_err}, 32'd0);
        areset = 1'b0;
        m_tready = 1'b1;
        tick();
        check("s6b_flushed", got_q.size(), 32'd0);
        ok0 = n_ok;
        tx_q = {8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
        send_q();
        drain_wait();
        exp_q = {9'h011, 9'h122};
        cmp_frame("s6b");
        check("s6_okcnt",  n_ok - ok0, 32'd1);
        check("s6_errcnt", n_err - err0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
